// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a uart_tx core.
//
// Bytes written by a producer are queued in a circular buffer and launched one at a time
// toward uart_tx: each launch pops the head entry into tx_byte and pulses tx_start for a
// single cycle.
//
// After a launch the block waits for tx_busy to rise and then fall before the next launch.
// If tx_busy never rises within BUSY_TIMEOUT cycles, the byte is treated as sent and the
// launcher frees up again.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   wr_en     in   write strobe
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds DEPTH entries (registered)
//   empty     out  FIFO holds 0 entries (registered)
//   count     out  occupancy, 0..DEPTH (registered)
//   overflow  out  one-cycle pulse after a dropped write
//   tx_start  out  one-cycle launch pulse to uart_tx
//   tx_byte   out  launched byte, held until the next launch
//   tx_busy   in   busy flag from uart_tx
module uart_tx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_start,
    output logic [7:0]               tx_byte,
    input  logic                     tx_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Timer counts 0..BUSY_TIMEOUT-1; keep at least one bit.
    localparam int unsigned TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitBusy,
        StWaitDone
    } state_e;

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    logic push;
    logic pop;

    // Launch is also held off while tx_busy is high, so a uart_tx still finishing a frame
    // (e.g. one started before a reset) never sees tx_start while it is busy.
    always_comb begin
        push = wr_en && !full_q;
        pop  = (state_q == StIdle) && !empty_q && !tx_busy;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_byte_d  = tx_byte_q;
        state_d    = state_q;
        timer_d    = timer_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_byte_d = mem[rd_ptr_q];
        end

        count_d    = count_q + CW'(push) - CW'(pop);
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = wr_en && full_q;
        tx_start_d = pop;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StWaitBusy;
                    timer_d = '0;
                end
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    // uart_tx never acknowledged; the byte is considered sent.
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            state_q    <= StIdle;
            timer_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;

endmodule
